// File: rtl/fifo_rd_pkg.sv
// Shared types, constants and small helpers for the FIFO burst reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fifo_rd_state_t;

  localparam int FIFO_RD_BUF_DEPTH = 3;
  localparam int FIFO_RD_STAT_W    = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [FIFO_RD_STAT_W-1:0] sat_inc(input logic [FIFO_RD_STAT_W-1:0] v);
    if (v == {FIFO_RD_STAT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(FIFO_RD_STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Advance a pointer around the 3-entry circular buffer.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    if (p == 2'd2) begin
      ptr_next = 2'd0;
    end else begin
      ptr_next = p + 2'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_rd_chk.sv
// Property checker for the burst reader: buffer never overflows, reads are
// only issued against a non-empty FIFO, and pending reads fit the FIFO depth.
module fifo_rd_chk
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  input logic       push,
  input logic [1:0] count,
  input logic       rd_en,
  input logic       fifo_empty
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (int'(count) < FIFO_RD_BUF_DEPTH));

  a_rd_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    rd_en |-> !fifo_empty);

  a_pending_fits: assert property (@(posedge clk) disable iff (!rst_n)
    rd_en |-> ((int'(push) + 1) <= FIFO_DEPTH));

endmodule

// File: rtl/fifo_rd_skid.sv
// 3-entry circular buffer with push/pop and occupancy count. Pop on an
// empty buffer is ignored; the head word is held stable until popped.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [FIFO_RD_BUF_DEPTH];
  logic [1:0]       wr_ptr_r;
  logic [1:0]       rd_ptr_r;
  logic [1:0]       count_r;
  logic             pop_s;

  assign pop_s = pop && (count_r != 2'd0);
  assign count = count_r;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_RD_BUF_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head-of-buffer select.
  always_comb begin
    head_data = mem_r[0];
    case (rd_ptr_r)
      2'd0:    head_data = mem_r[0];
      2'd1:    head_data = mem_r[1];
      2'd2:    head_data = mem_r[2];
      default: head_data = mem_r[0];
    endcase
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read engine for the synchronous FIFO: drains burst_len words and
// streams them on valid/ready, hiding the FIFO's one-cycle read latency.
// Optional statistics outputs are enabled with `define FIFO_RD_STATS_EN.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic                 busy,
  output logic                 done,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_data_out,
  input  logic                 fifo_empty,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [FIFO_RD_STAT_W-1:0] word_cnt,
  output logic [FIFO_RD_STAT_W-1:0] stall_cnt
`endif
);

  localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;

  fifo_rd_state_t       state_r;
  fifo_rd_state_t       next_state_s;
  logic [LEN_WIDTH-1:0] to_issue_r;
  logic                 inflight_r;
  logic [1:0]           count_s;
  logic                 pop_s;
  logic                 rd_en_s;
  logic                 accept_s;
  logic                 drained_s;
  logic                 issue_left_s;

  assign accept_s     = (state_r == IDLE) && start;
  assign issue_left_s = (to_issue_r != {LEN_WIDTH{1'b0}});
  assign pop_s        = m_valid && m_ready;

  assign busy       = (state_r != IDLE);
  assign done       = (state_r == DONE);
  assign fifo_rd_en = rd_en_s;
  assign m_valid    = (count_s != 2'd0);

  fifo_rd_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (fifo_data_out),
    .pop       (pop_s),
    .head_data (m_data),
    .count     (count_s)
  );

  fifo_rd_chk #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_r),
    .count      (count_s),
    .rd_en      (rd_en_s),
    .fifo_empty (fifo_empty)
  );

  // Buffer empties this cycle when nothing is left after the current pop.
  always_comb begin
    drained_s = 1'b0;
    if (count_s == 2'd0) begin
      drained_s = 1'b1;
    end else if ((count_s == 2'd1) && pop_s) begin
      drained_s = 1'b1;
    end else begin
      drained_s = 1'b0;
    end
  end

  // Next-state and read-issue logic; reads never wait on m_ready, only on
  // buffer space (buffered + in-flight words capped at 3).
  always_comb begin
    next_state_s = state_r;
    rd_en_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (burst_len != {LEN_WIDTH{1'b0}}) begin
            next_state_s = RUN;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        rd_en_s = !fifo_empty && issue_left_s &&
                  (({1'b0, count_s} + {2'b00, inflight_r}) <= 3'd2);
        if (!issue_left_s && !inflight_r && drained_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Remaining-read counter and one-cycle read-latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_issue_r <= {LEN_WIDTH{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      if (accept_s) begin
        to_issue_r <= burst_len;
      end else if (rd_en_s) begin
        to_issue_r <= to_issue_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        to_issue_r <= to_issue_r;
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [FIFO_RD_STAT_W-1:0] word_cnt_r;
  logic [FIFO_RD_STAT_W-1:0] stall_cnt_r;

  assign word_cnt  = word_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Per-burst handshake and FIFO-empty stall counters, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_r  <= {FIFO_RD_STAT_W{1'b0}};
      stall_cnt_r <= {FIFO_RD_STAT_W{1'b0}};
    end else if (accept_s) begin
      word_cnt_r  <= {FIFO_RD_STAT_W{1'b0}};
      stall_cnt_r <= {FIFO_RD_STAT_W{1'b0}};
    end else begin
      if (pop_s) begin
        word_cnt_r <= sat_inc(word_cnt_r);
      end
      if ((state_r == RUN) && issue_left_s && fifo_empty) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
    end
  end
`endif

endmodule
